div8b_seq: RTL

Sequential 8-bit unsigned restoring divider. It is the inverse counterpart of the ripple adder8b: a shift-and-subtract datapath that produces a quotient and remainder over multiple clock cycles. It uses a start/done handshake and sits beside the ALU datapath as a multi-cycle arithmetic unit. Subtraction is done by adding the inverted divisor with carry-in 1, one trial subtraction per cycle.

---
 rtl/div8b_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/div8b_seq.sv
// Sequential unsigned restoring divider: one shift-and-subtract step per clock, with a
// start/done handshake. Trial subtraction adds the inverted divisor with carry-in 1.
module div8b_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned IterW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     r_work_q, r_work_d;
  logic [WIDTH-1:0]   q_work_q, q_work_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [IterW-1:0]   iter_q, iter_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   sum;
  logic               no_borrow;
  logic [WIDTH:0]     r_next;
  logic [WIDTH-1:0]   q_next;
  // An accepted trial is always below the divisor, so the stored top bit is never read.
  logic               unused_r_msb;

  assign unused_r_msb = r_work_q[WIDTH];

  always_comb begin
    shifted   = {r_work_q[WIDTH-1:0], q_work_q[WIDTH-1]};
    // Carry out of shifted + ~{0,D} + 1 is set exactly when no borrow occurs.
    sum       = {1'b0, shifted} + {1'b0, ~{1'b0, d_q}} + (WIDTH+2)'(1);
    no_borrow = sum[WIDTH+1];
    r_next    = no_borrow ? sum[WIDTH:0] : shifted;
    q_next    = {q_work_q[WIDTH-2:0], no_borrow};

    state_d     = state_q;
    r_work_d    = r_work_q;
    q_work_d    = q_work_q;
    d_d         = d_q;
    iter_d      = iter_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          q_work_d = dividend;
          d_d      = divisor;
          r_work_d = '0;
          iter_d   = '0;
          if (divisor != '0) begin
            state_d = StRun;
          end else begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
          end
        end
      end
      StRun: begin
        r_work_d = r_next;
        q_work_d = q_next;
        iter_d   = iter_q + IterW'(1);
        if (iter_q == IterW'(WIDTH-1)) begin
          state_d     = StDone;
          quotient_d  = q_next;
          remainder_d = r_next[WIDTH-1:0];
          dbz_d       = 1'b0;
          done_d      = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      r_work_q    <= '0;
      q_work_q    <= '0;
      d_q         <= '0;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_work_q    <= r_work_d;
      q_work_q    <= q_work_d;
      d_q         <= d_d;
      iter_q      <= iter_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
